// File: rtl/buffer_lru_dump.sv
// Snapshots the LRU buffer array on start_i and streams emittable slots as (idx, data, last) words.
// Latency: first word one cycle after start if slot 0 is emittable; done_o pulses one cycle after the last handshake.
// Backpressure: valid/ready; the word holds stable until accepted, with no combinational path from ready_i.
module buffer_lru_dump #(
    parameter int  WIDTH     = 16,
    parameter int  BUF_SIZE  = 8,
    parameter bit  SKIP_ZERO = 1'b1,
    localparam int IW        = $clog2(BUF_SIZE),
    localparam int CW        = $clog2(BUF_SIZE + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [BUF_SIZE-1:0][WIDTH-1:0]     buf_array_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [WIDTH-1:0]                   data_o,
    output logic [IW-1:0]                      idx_o,
    output logic                               last_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [CW-1:0]                      count_o
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [BUF_SIZE-1:0][WIDTH-1:0] snap;
    logic [IW-1:0]                  ptr;
    logic [CW-1:0]                  count_q;
    logic [BUF_SIZE-1:0]            emit;
    logic                           pending;
    logic                           above;
    logic                           cur_emit;
    logic                           fire;

    // pending: something emittable at or past ptr; above: strictly past ptr (drives last_o)
    always_comb begin
        emit    = '0;
        pending = 1'b0;
        above   = 1'b0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            emit[i] = !SKIP_ZERO || (snap[i] != '0);
            if (emit[i] && (IW'(i) >= ptr)) pending = 1'b1;
            if (emit[i] && (IW'(i) >  ptr)) above   = 1'b1;
        end
    end

    assign cur_emit = emit[ptr];
    assign fire     = (state == SCAN) && cur_emit && ready_i;
    assign count_o  = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = SCAN;
            SCAN: begin
                if (!pending)            state_nxt = DONE;
                else if (fire && !above) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        last_o  = 1'b0;
        data_o  = '0;
        idx_o   = '0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state)
            SCAN: begin
                busy_o  = 1'b1;
                valid_o = cur_emit;
                last_o  = cur_emit && !above;
                if (cur_emit) begin
                    data_o = snap[ptr];
                    idx_o  = ptr;
                end
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // ptr never advances past the top slot: a skip there leaves nothing pending, and a non-last word implies a higher slot
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            snap    <= '0;
            ptr     <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        snap    <= buf_array_i;
                        ptr     <= '0;
                        count_q <= '0;
                    end
                end
                SCAN: begin
                    if (pending) begin
                        if (!cur_emit) begin
                            ptr <= ptr + IW'(1);
                        end else if (fire) begin
                            count_q <= count_q + CW'(1);
                            if (above) ptr <= ptr + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
